mult32_iter: RTL and testbench
==============================

# mult32_iter

Iterative 32×32→64 multiplier for the ALU, consuming the same 32-bit operand buses that feed the bitwise logic units. It produces HI/LO product words for MULT/MULTU-style instructions. It trades area for latency by using one 32-bit add per cycle over 32 cycles. A START/BUSY/DONE handshake lets the control unit stall until the product is ready.

## Interface
Parameters:
- None. The operand width is fixed at 32, with a 64-bit product.

Ports (one clock; reset is asynchronous and active-low):
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; captured with START.
- A  input  32  multiplicand; captured with START.
- B  input  32  multiplier; captured with START.
- HI  output  32  product bits [63:32].
- LO  output  32  product bits [31:0].
- BUSY  output  1  high from the cycle after START is accepted through the FIX cycle.
- DONE  output  1  one-cycle pulse when HI/LO become valid.

## Operation
- Reset (RST=0, asynchronous): state=IDLE; HI=LO=0; BUSY=0; DONE=0; all internal registers are 0.
- States: IDLE → RUN → FIX → DONE → IDLE.
- IDLE:
  - When START=1, capture operand magnitudes:
    - If SIGNED and A[31], MA = −A; otherwise MA = A. MB is handled the same way.
    - NEG = SIGNED & (A[31] ^ B[31]).
  - Clear the 64-bit accumulator P; set the iteration count to 0; go to RUN.
  - When START=0, stay in IDLE.
- RUN (32 cycles):
  - Each cycle, if MB[0], add MA into P[63:32] as a 33-bit sum including carry.
  - Then shift {carry, P, MB} right by one.
  - Go to FIX after count 31.
- FIX:
  - If NEG, set P = −P (64-bit two's complement); otherwise leave P unchanged.
  - Load HI/LO from P. Go to DONE.
- DONE: DONE=1 for this cycle only; BUSY=0. Go to IDLE.
- HI/LO hold their value until the FIX cycle of the next operation. They do not change during RUN.
- START while BUSY=1 or DONE=1 is ignored. It is not queued.
- A, B and SIGNED are don't-care after the START capture cycle.
- Magnitude of 0x80000000 is 2^31, which is representable unsigned in 32 bits. The maximum product magnitude is 2^62, so the accumulator cannot overflow.
- An unsigned product with SIGNED=0 is never negated.
- Reset asserted mid-operation aborts immediately to the reset values. No DONE is produced for the aborted request.

## Timing
- Cycle 0: START=1 sampled in IDLE.
- Cycles 1–32: RUN. BUSY=1 from cycle 1.
- Cycle 33: FIX. BUSY=1; HI/LO are registered at the end of this cycle.
- Cycle 34: DONE=1, BUSY=0, HI/LO valid.
- Cycle 35: earliest next START acceptance, giving a throughput of one product per 35 cycles.
- Total latency is 34 cycles from the START edge to DONE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - The width constant (32).
  - State encodings (IDLE, RUN, FIX, DONE; 2 bits).
  - The iteration-count width (5 bits).
- One sub-module, `twos_comp_n` (parameter WIDTH; Y = ~A + 1):
  - Instantiated at WIDTH=32 twice, for operand magnitudes.
  - Instantiated at WIDTH=64 once, for the final negation.
  - Built from the existing 32-bit inverter and adder style.
- Top-level contents:
  - The FSM and the 5-bit counter.
  - The 32-bit MA register.
  - The 64-bit P/MB shift register.
  - The HI/LO output registers.

## Test plan
- Unsigned 3×5: A=3, B=5, SIGNED=0 → DONE at cycle 34, HI=0x00000000, LO=0x0000000F. BUSY is high on cycles 1–33 only.
- Unsigned max: A=B=0xFFFFFFFF, SIGNED=0 → HI=0xFFFFFFFE, LO=0x00000001.
- Signed mixed and extremes:
  - −3×7: A=0xFFFFFFFD, B=7, SIGNED=1 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - 0x80000000×0x80000000, SIGNED=1 → HI=0x40000000, LO=0x00000000.
  - −1×−1 → HI=0, LO=1.
- START ignored while busy:
  - Start 6×7, then pulse START with A=2, B=2 at cycle 10 → single DONE at cycle 34 with LO=42 (0x2A).
  - The next START, accepted at cycle 35, yields DONE at cycle 69.
- Reset mid-operation:
  - After a completed product, start a new one and drive RST=0 at cycle 15 → HI=LO=0, BUSY=0, DONE=0 immediately, and no DONE pulse follows.
  - After RST=1, A=10, B=10 → LO=100 at +34 cycles.
- Output hold: after DONE, toggle A/B/SIGNED with START=0 for 20 cycles → HI/LO unchanged, DONE stays 0.

Source files
------------

// File: rtl/mult32_iter_pkg.sv
// Shared constants and state encoding for the iterative 32x32 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult32_iter_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/twos_comp_n.sv
// Two's-complement negation: y = ~a + 1.
// Latency: combinational.
// Backpressure: none.
module twos_comp_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/mult32_iter.sv
// Iterative 32x32->64 signed/unsigned shift-add multiplier with START/BUSY/DONE.
// Latency: 34 cycles from START capture to DONE; one product per 35 cycles.
// Backpressure: START is sampled only in IDLE; requests while busy are dropped.
import mult32_iter_pkg::*;

module mult32_iter (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              SIGNED,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              BUSY,
  output logic              DONE
);

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   ma;
  logic [PROD_W-1:0]   pmb;   // {accumulator high half, multiplier / low product bits}
  logic                neg;
  logic                busy_nxt;
  logic                done_nxt;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   neg_a;
  logic [DATA_W-1:0]   neg_b;
  logic [PROD_W-1:0]   neg_p;

  twos_comp_n #(.WIDTH(DATA_W)) u_neg_a (.a(A),   .y(neg_a));
  twos_comp_n #(.WIDTH(DATA_W)) u_neg_b (.a(B),   .y(neg_b));
  twos_comp_n #(.WIDTH(PROD_W)) u_neg_p (.a(pmb), .y(neg_p));

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (START) next_state = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(DATA_W - 1)) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode, computed from the next state so BUSY/DONE can be registered
  always_comb begin
    busy_nxt = (next_state == ST_RUN) || (next_state == ST_FIX);
    done_nxt = (next_state == ST_DONE);
  end

  // Registered handshake outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      BUSY <= busy_nxt;
      DONE <= done_nxt;
    end
  end

  // 33-bit partial sum: add the multiplicand when the current multiplier bit is set
  always_comb begin
    sum = {1'b0, pmb[PROD_W-1:DATA_W]};
    if (pmb[0]) sum = sum + {1'b0, ma};
  end

  // Datapath: operand capture, shift-add iterations, sign fix and result load
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      ma  <= '0;
      pmb <= '0;
      neg <= 1'b0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            ma  <= (SIGNED && A[DATA_W-1]) ? neg_a : A;
            pmb <= {{DATA_W{1'b0}}, ((SIGNED && B[DATA_W-1]) ? neg_b : B)};
            neg <= SIGNED & (A[DATA_W-1] ^ B[DATA_W-1]);
            cnt <= '0;
          end
        end
        ST_RUN: begin
          // shift {carry, sum, low bits} right by one; the consumed multiplier bit drops out
          pmb <= {sum, pmb[DATA_W-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          // magnitude never exceeds 2^62, so negation of the full 64 bits is exact
          {HI, LO} <= neg ? neg_p : pmb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_iter.sv
// Self-checking bench for mult32_iter: directed cases plus randomized operands
// checked against a plain-arithmetic 64-bit product model.
module tb_mult32_iter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BUSY;
  logic        DONE;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_cnt = 0;
  int last_start;
  int last_done;
  logic [63:0] last_prod;

  mult32_iter dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits by its interpretation, multiply modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge CLK);
    A = a; B = b; SIGNED = s; START = 1'b1;
    last_start = cycle_cnt;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = $urandom; B = $urandom; SIGNED = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int ignore_at, input bit start_in_done);
    logic [63:0] exp;
    logic [63:0] got;
    int cyc, done_cyc, busy_bad, hold_bad;
    exp = ref_prod(a, b, s);
    got = '0;
    issue(a, b, s);
    cyc = 1; done_cyc = 0; busy_bad = 0; hold_bad = 0;
    while (done_cyc == 0 && cyc <= 40) begin
      @(negedge CLK);
      if (DONE) begin
        done_cyc  = cyc;
        got       = {HI, LO};
        last_done = cycle_cnt;
        if (BUSY !== 1'b0) busy_bad++;
        if (start_in_done) START = 1'b1;
      end else begin
        if (BUSY !== (cyc <= 33)) busy_bad++;
        if ({HI, LO} !== last_prod) hold_bad++;
      end
      if (cyc == ignore_at) begin
        START = 1'b1; A = 32'd2; B = 32'd2;
      end
      @(posedge CLK);
      #1;
      START = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(done_cyc), 64'd34);
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    chk({tag, "_hold_run"}, 64'(hold_bad), 64'd0);
    chk({tag, "_product"}, got, exp);
    last_prod = exp;
    if (start_in_done) begin
      @(negedge CLK);
      chk({tag, "_start_in_done_ignored"}, {62'b0, BUSY, DONE}, 64'd0);
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0 || {HI, LO} !== last_prod) bad++;
      A = $urandom; B = $urandom; SIGNED = 1'($urandom);
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    int s1;
    RST = 1'b0; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    last_prod = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_hilo", {HI, LO}, 64'd0);
    chk("reset_busy_done", {62'b0, BUSY, DONE}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    // directed test-plan cases
    run_op("u3x5", 32'd3, 32'd5, 1'b0, 0, 1'b0);
    chk("u3x5_const", last_prod, 64'h0000_0000_0000_000F);
    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    chk("umax_const", last_prod, 64'hFFFF_FFFE_0000_0001);
    run_op("sm3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 0, 1'b1);
    chk("sm3x7_const", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
    chk("smin2_const", last_prod, 64'h4000_0000_0000_0000);
    run_op("sm1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    chk("sm1m1_const", last_prod, 64'd1);

    // START ignored while busy, then back-to-back throughput
    run_op("ign6x7", 32'd6, 32'd7, 1'b0, 10, 1'b0);
    chk("ign6x7_lo", last_prod, 64'd42);
    s1 = last_start;
    run_op("b2b", pick_operand(), pick_operand(), 1'($urandom), 0, 1'b0);
    chk("b2b_throughput", 64'(last_done - s1), 64'd69);

    // output hold with toggling inputs
    idle_watch("hold_idle", 20);

    // reset mid-operation
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (14) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_hilo", {HI, LO}, 64'd0);
    chk("midrst_busy_done", {62'b0, BUSY, DONE}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    last_prod = '0;
    idle_watch("midrst_no_done", 40);
    run_op("post_rst10x10", 32'd10, 32'd10, 1'b0, 0, 1'b0);
    chk("post_rst_const", last_prod, 64'd100);

    // randomized operands
    for (int i = 0; i < 40; i++) begin
      run_op("rand", pick_operand(), pick_operand(), 1'($urandom), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
